// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped N-pin GPIO with direction, atomic set/clear and edge interrupts
module gpio_bank #(
  parameter int DW = 16,
  parameter int AW = 13,
  parameter int N = 16,
  parameter logic [AW-1:0] BASE = '0,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic [AW-1:0] addr,
  input  logic          we,
  output logic [DW-1:0] dout,
  input  logic [N-1:0]  gpio_in,
  output logic [N-1:0]  gpio_out,
  output logic [N-1:0]  gpio_oe,
  output logic          irq
);
  logic [AW-1:0] off;
  logic          hit;
  logic          wr;
  logic [2:0]    idx;
  logic [N-1:0]  wd;
  logic [N-1:0]  sin;
  logic [N-1:0]  hist;
  logic [N-1:0]  evt;
  logic [N-1:0]  out_r, dir_r, ie_r, pol_r, is_r;
  logic [N-1:0]  out_n, is_n, rd_n;
  logic [N-1:0]  sync [SYNC_STAGES];
  // An address below BASE wraps to a large offset, so one compare covers both ends of the window
  assign off = addr - BASE;
  assign hit = off < AW'(8);
  assign idx = off[2:0];
  assign wr  = we & hit;
  assign wd  = din[N-1:0];
  assign sin = sync[SYNC_STAGES-1];
  // Edge events, next OUT (full-register read-modify-write) and next IS (set beats W1C)
  always_comb begin
    evt   = (pol_r & sin & ~hist) | (~pol_r & ~sin & hist);
    out_n = !wr            ? out_r :
            idx == 3'd1    ? wd :
            idx == 3'd3    ? out_r | wd :
            idx == 3'd4    ? out_r & ~wd : out_r;
    is_n  = (is_r & ~((wr && idx == 3'd7) ? wd : '0)) | evt;
    rd_n  = idx == 3'd0 ? sin :
            idx == 3'd1 ? out_r :
            idx == 3'd2 ? dir_r :
            idx == 3'd5 ? ie_r :
            idx == 3'd6 ? pol_r :
            idx == 3'd7 ? is_r : '0;
  end
  // Input synchroniser chain and edge history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '{default: '0};
      hist <= '0;
    end else begin
      sync[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      hist <= sin;
    end
  end
  // Software-visible registers and registered read port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r <= '0;
      dir_r <= '0;
      ie_r  <= '0;
      pol_r <= '0;
      is_r  <= '0;
      dout  <= '0;
    end else begin
      out_r <= out_n;
      dir_r <= (wr && idx == 3'd2) ? wd : dir_r;
      ie_r  <= (wr && idx == 3'd5) ? wd : ie_r;
      pol_r <= (wr && idx == 3'd6) ? wd : pol_r;
      is_r  <= is_n;
      if (!we) dout <= hit ? DW'(rd_n) : '0;
    end
  end
  assign gpio_out = out_r;
  assign gpio_oe  = dir_r;
  assign irq      = |(is_r & ie_r);
endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed and random checks of gpio_bank against a cycle-level reference model
module tb_gpio_bank;
  logic        clk, rst, run;
  logic [15:0] din, dout, gpio_in, gpio_out, gpio_oe;
  logic [12:0] addr;
  logic        we, irq;
  logic [15:0] din8, dout8;
  logic [12:0] addr8;
  logic        we8, irq8;
  logic [7:0]  gin8, gout8, goe8;
  int vectors = 0;
  int errors = 0;
  int t;
  logic [15:0] ph[$];
  logic [15:0] m_out, m_dir, m_ie, m_pol, m_is, m_dout;

  gpio_bank dut (
    .clk(clk), .rst(rst), .din(din), .addr(addr), .we(we), .dout(dout),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  gpio_bank #(.N(8), .BASE(13'h020), .SYNC_STAGES(3)) u8 (
    .clk(clk), .rst(rst), .din(din8), .addr(addr8), .we(we8), .dout(dout8),
    .gpio_in(gin8), .gpio_out(gout8), .gpio_oe(goe8), .irq(irq8)
  );

  always #5 if (run) clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pin_at(input int k);
    if (k < 1) return 16'h0;
    return ph[k-1];
  endfunction

  task automatic model_reset();
    t = 0;
    ph.delete();
    {m_out, m_dir, m_ie, m_pol, m_is, m_dout} = '0;
  endtask

  task automatic step(input logic w, input logic [12:0] a, input logic [15:0] d);
    logic [15:0] cur, prev, evt, rv;
    logic        hit;
    logic [2:0]  o;
    we = w; addr = a; din = d;
    t++;
    ph.push_back(gpio_in);
    cur  = pin_at(t - 2);
    prev = pin_at(t - 3);
    hit  = a < 13'd8;
    o    = a[2:0];
    case (o)
      3'd0: rv = cur;
      3'd1: rv = m_out;
      3'd2: rv = m_dir;
      3'd5: rv = m_ie;
      3'd6: rv = m_pol;
      3'd7: rv = m_is;
      default: rv = 16'h0;
    endcase
    @(posedge clk);
    if (!w) m_dout = hit ? rv : 16'h0;
    evt  = (m_pol & cur & ~prev) | (~m_pol & ~cur & prev);
    m_is = (m_is & ~((w && hit && o == 3'd7) ? d : 16'h0)) | evt;
    if (w && hit)
      case (o)
        3'd1: m_out = d;
        3'd2: m_dir = d;
        3'd3: m_out = m_out | d;
        3'd4: m_out = m_out & ~d;
        3'd5: m_ie = d;
        3'd6: m_pol = d;
        default: ;
      endcase
    #1;
    check("gpio_out", gpio_out, m_out);
    check("gpio_oe", gpio_oe, m_dir);
    check("irq", {15'h0, irq}, {15'h0, |(m_is & m_ie)});
    check("dout", dout, m_dout);
    we = 0;
  endtask

  task automatic step8(input logic w, input logic [12:0] a, input logic [15:0] d);
    we8 = w; addr8 = a; din8 = d;
    step(0, 13'd0, 16'h0);
    we8 = 0; addr8 = 13'h1FFF;
  endtask

  initial begin
    clk = 0; run = 0; rst = 0;
    we = 0; addr = 0; din = 0; gpio_in = 0;
    we8 = 0; addr8 = 13'h1FFF; din8 = 0; gin8 = 0;
    #2 rst = 1;
    #1;
    check("rst_gpio_out", gpio_out, 16'h0);
    check("rst_gpio_oe", gpio_oe, 16'h0);
    check("rst_irq", {15'h0, irq}, 16'h0);
    check("rst_dout", dout, 16'h0);
    check("rst_dout8", dout8, 16'h0);
    run = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      step(0, 13'(i), 16'h0);
      check("reset_read", dout, 16'h0);
    end
    step(1, 13'd2, 16'h00FF);
    step(1, 13'd1, 16'h1234);
    step(1, 13'd3, 16'h0003);
    step(1, 13'd4, 16'h0030);
    check("oe_const", gpio_oe, 16'h00FF);
    check("out_const", gpio_out, 16'h1207);
    step(0, 13'd1, 16'h0);
    check("rd_out", dout, 16'h1207);
    step(0, 13'd3, 16'h0);
    check("rd_set", dout, 16'h0);
    gpio_in = 16'hA5A5;
    step(0, 13'd0, 16'h0);
    check("in_lat_k", dout, 16'h0);
    step(0, 13'd0, 16'h0);
    check("in_lat_k1", dout, 16'h0);
    step(0, 13'd0, 16'h0);
    check("in_lat_k2", dout, 16'hA5A5);
    gpio_in = 16'h0002;
    repeat (4) step(0, 13'd0, 16'h0);
    step(1, 13'd7, 16'hFFFF);
    step(1, 13'd6, 16'h0001);
    step(1, 13'd5, 16'h0003);
    check("irq_idle", {15'h0, irq}, 16'h0);
    gpio_in = 16'h0001;
    repeat (3) step(0, 13'd0, 16'h0);
    step(0, 13'd7, 16'h0);
    check("is_both", dout, 16'h0003);
    check("irq_both", {15'h0, irq}, 16'h1);
    step(1, 13'd7, 16'h0001);
    check("irq_after_w1c0", {15'h0, irq}, 16'h1);
    step(0, 13'd7, 16'h0);
    check("is_after_w1c0", dout, 16'h0002);
    step(1, 13'd5, 16'h0000);
    check("irq_ie_off", {15'h0, irq}, 16'h0);
    step(0, 13'd7, 16'h0);
    check("is_kept", dout, 16'h0002);
    step(1, 13'd5, 16'h0003);
    check("irq_ie_on", {15'h0, irq}, 16'h1);
    step(1, 13'd7, 16'h0002);
    check("irq_cleared", {15'h0, irq}, 16'h0);
    gpio_in = 16'h0000;
    repeat (3) step(0, 13'd0, 16'h0);
    gpio_in = 16'h0001;
    step(0, 13'd0, 16'h0);
    step(0, 13'd0, 16'h0);
    step(1, 13'd7, 16'h0001);
    step(0, 13'd7, 16'h0);
    check("set_wins", dout, 16'h0001);
    step(1, 13'd9, 16'hFFFF);
    step(0, 13'd9, 16'h0);
    check("rd_unmapped", dout, 16'h0);
    step(0, 13'd1, 16'h0);
    check("out_untouched", dout, 16'h1207);
    step8(1, 13'h021, 16'hFFFF);
    check("n8_gpio_out", {8'h0, gout8}, 16'h00FF);
    step8(0, 13'h021, 16'h0);
    check("n8_rd_out", dout8, 16'h00FF);
    step8(1, 13'h029, 16'h1234);
    step8(1, 13'h001, 16'h0000);
    step8(0, 13'h029, 16'h0);
    check("n8_rd_unmapped", dout8, 16'h0);
    step8(0, 13'h021, 16'h0);
    check("n8_out_kept", dout8, 16'h00FF);
    step8(0, 13'h024, 16'h0);
    check("n8_rd_clr", dout8, 16'h0);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) gpio_in = 16'($urandom);
      step(1'($urandom_range(1)), 13'($urandom_range(9)), 16'($urandom));
    end
    m_out = 16'h0;
    step(1, 13'd1, 16'hBEEF);
    step(1, 13'd2, 16'h0F0F);
    rst = 1;
    #1;
    check("midrst_gpio_out", gpio_out, 16'h0);
    check("midrst_gpio_oe", gpio_oe, 16'h0);
    check("midrst_irq", {15'h0, irq}, 16'h0);
    check("midrst_dout", dout, 16'h0);
    @(posedge clk);
    #1 rst = 0;
    model_reset();
    step(0, 13'd1, 16'h0);
    check("post_rst_out", dout, 16'h0);
    repeat (6) step(0, 13'd7, 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
